register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//   Parametrised multi-read-port integer register file with a per-register busy scoreboard,
//   optional write-through bypass and a sequential bulk-clear engine.
//   Sits in the decode stage of the RV core: decode reads operands and the busy bits here.
//   Decode also marks destination registers busy at issue. Writeback writes results and clears busy.
// PARAMETERS
//   XLEN          32  data width of each register
//   NUM_REGS      32  number of architectural registers (>=2); AW = $clog2(NUM_REGS) is a localparam
//   NUM_RD_PORTS   2  number of independent read ports (>=1)
//   ZERO_REG       1  1: register 0 is hardwired to zero and never busy
//   BYPASS         1  1: a same-cycle write is forwarded to matching read ports
// PORTS
//   clock_i           in   1                 clock, rising edge
//   reset_i           in   1                 asynchronous reset, active-low
//   rd_register_i     in   NUM_RD_PORTS*AW   read addresses; port p = [p*AW +: AW]
//   rd_data_o         out  NUM_RD_PORTS*XLEN read data; port p = [p*XLEN +: XLEN]
//   rd_busy_o         out  NUM_RD_PORTS      busy bit of the addressed register, per port
//   reg_write_i       in   1                 write enable
//   wr_register_i     in   AW                write address
//   wr_data_i         in   XLEN              write data
//   issue_i           in   1                 mark issue_register_i busy
//   issue_register_i  in   AW                destination register being issued
//   clear_i           in   1                 start a bulk clear of all registers
//   clearing_o        out  1                 high while the clear engine is running
// BEHAVIOUR
//   Reset (reset_i=0, async): all registers=0, all busy=0, FSM=IDLE, counter=0, clearing_o=0.
//   Reads are combinational. Each port's rd_data_o/rd_busy_o is 0 when:
//     - the address is >= NUM_REGS, or
//     - the address is 0 and ZERO_REG=1.
//   Bypass (BYPASS=1): rd_data_o=wr_data_i and rd_busy_o=0 when all of these hold:
//     - reg_write_i=1 and clearing_o=0;
//     - wr_register_i == rd address;
//     - the address is valid and is not the hardwired zero register.
//     All ports bypass independently. BYPASS=0: reads see the array only (old value until the edge).
//   Write: commits on the rising edge when reg_write_i=1, clearing_o=0, the address is valid and
//     is not the hardwired zero register. Otherwise the write is dropped. Write latency is 1 edge.
//   Scoreboard (updated on the rising edge, ignored while clearing_o=1):
//     - a write clears busy[wr_register_i];
//     - issue_i sets busy[issue_register_i];
//     - issue and write to the same register in one cycle: the set wins (the new producer is pending);
//     - issue to the hardwired zero register or to an invalid address is ignored;
//     - issue of an already-busy register leaves it busy.
//   Clear FSM, states IDLE and CLEAR:
//     IDLE: clear_i=1 -> CLEAR with counter=0. A write or issue in that same cycle still commits.
//     CLEAR: each edge sets reg[counter]=0 and busy[counter]=0, then counter++.
//       When counter==NUM_REGS-1 -> IDLE and counter=0.
//       clearing_o=1 for exactly NUM_REGS cycles. clear_i is ignored in CLEAR.
//       Writes and issues are dropped. Reads return the current array contents, no bypass.
//   Reset mid-clear: clearing_o=0 immediately, FSM=IDLE, all registers and busy bits are 0.
//   No X propagation: any address with x/invalid bits must not corrupt state. Out-of-range writes are dropped.
// TESTING
//   1 Reset: reset_i=0 with random inputs -> all rd_data_o=0, rd_busy_o=0, clearing_o=0; release -> unchanged.
//   2 Write x1=0x55555555 while port0 reads x1 -> port0=0x55555555 same cycle (BYPASS=1);
//     the value persists after reg_write_i=0. With BYPASS=0, port0 shows 0 until the edge.
//   3 Write x0=0xAAAAAAAA and issue x0 -> reading x0 gives 0 with busy=0. Writing x2=0xAAAAAAAA
//     -> port0=x2 and port1=x1 (0x55555555) at the same time.
//   4 Issue x5 -> rd_busy=1 next cycle. Write x5=0x00001234 -> busy=0, data=0x1234.
//     Issue+write x5=0xBEEF in the same cycle -> data=0xBEEF, busy stays 1.
//   5 x1, x2 written and x5 busy; pulse clear_i -> clearing_o=1 for exactly NUM_REGS cycles.
//     A write x3=0x1 during the sweep is dropped. Afterwards all regs=0 and all busy=0.
//   6 Assert reset_i=0 on sweep cycle 10 -> clearing_o drops asynchronously and all reads=0.
//     After release, a write x7=0xCAFE commits normally.

Source files
------------

// File: rtl/register_file_sb.sv
// Integer register file for the decode stage: combinational multi-port reads,
// a per-register busy scoreboard (set at issue, cleared at writeback),
// optional same-cycle write forwarding and a one-register-per-cycle clear sweep.
module register_file_sb #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_register_i,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data_o,
  output logic [NUM_RD_PORTS-1:0]      rd_busy_o,
  input  logic                         reg_write_i,
  input  logic [AW-1:0]                wr_register_i,
  input  logic [XLEN-1:0]              wr_data_i,
  input  logic                         issue_i,
  input  logic [AW-1:0]                issue_register_i,
  input  logic                         clear_i,
  output logic                         clearing_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [XLEN-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic              wr_fire;
  logic              iss_fire;
  logic [AW-1:0]     rd_addr;

  // An address is usable when it names a real register that is not the hardwired zero.
  // An x address compares as unknown and therefore never enables an update.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign clearing_o = (state_q == CLEAR);
  assign wr_fire    = reg_write_i && (state_q == IDLE) && addr_ok(wr_register_i);
  assign iss_fire   = issue_i && (state_q == IDLE) && addr_ok(issue_register_i);

  // Next-state: writeback/issue in IDLE (issue applied last so it wins), sweep in CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (wr_fire) begin
          regs_d[wr_register_i] = wr_data_i;
          busy_d[wr_register_i] = 1'b0;
        end
        if (iss_fire) begin
          busy_d[issue_register_i] = 1'b1;
        end
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        if (cnt_q == AW'(NUM_REGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, array and scoreboard registers; reset empties everything at once.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: forward an accepted same-cycle write, otherwise show the array.
  // Forwarding is suppressed while in reset so reads are zero during reset.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_addr   = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_addr = rd_register_i[p*AW +: AW];
      if (addr_ok(rd_addr)) begin
        if ((BYPASS != 0) && reset_i && wr_fire && (wr_register_i == rd_addr)) begin
          rd_data_o[p*XLEN +: XLEN] = wr_data_i;
          rd_busy_o[p]              = 1'b0;
        end else begin
          rd_data_o[p*XLEN +: XLEN] = regs_q[rd_addr];
          rd_busy_o[p]              = busy_q[rd_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: a bypassing and a non-bypassing
// instance share all inputs; expected outputs come from an array model.
module tb_register_file_sb;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int NRP = 2;
  localparam int AW = 5;

  typedef struct packed {
    logic [NRP*XLEN-1:0] data;
    logic [NRP-1:0]      busy;
    logic                clr;
    logic [NRP*XLEN-1:0] nb_data;
    logic [NRP-1:0]      nb_busy;
  } exp_t;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic                 reset_i = 1'b0;
  logic [NRP*AW-1:0]    rd_register_i = '0;
  logic [NRP*XLEN-1:0]  rd_data_o, nb_rd_data_o;
  logic [NRP-1:0]       rd_busy_o, nb_rd_busy_o;
  logic                 reg_write_i = 1'b0;
  logic [AW-1:0]        wr_register_i = '0;
  logic [XLEN-1:0]      wr_data_i = '0;
  logic                 issue_i = 1'b0;
  logic [AW-1:0]        issue_register_i = '0;
  logic                 clear_i = 1'b0;
  logic                 clearing_o, nb_clearing_o;

  register_file_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD_PORTS(NRP),
                     .ZERO_REG(1), .BYPASS(1)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .rd_register_i(rd_register_i),
    .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o), .reg_write_i(reg_write_i),
    .wr_register_i(wr_register_i), .wr_data_i(wr_data_i), .issue_i(issue_i),
    .issue_register_i(issue_register_i), .clear_i(clear_i), .clearing_o(clearing_o));

  register_file_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD_PORTS(NRP),
                     .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clock_i(clock_i), .reset_i(reset_i), .rd_register_i(rd_register_i),
    .rd_data_o(nb_rd_data_o), .rd_busy_o(nb_rd_busy_o), .reg_write_i(reg_write_i),
    .wr_register_i(wr_register_i), .wr_data_i(wr_data_i), .issue_i(issue_i),
    .issue_register_i(issue_register_i), .clear_i(clear_i), .clearing_o(nb_clearing_o));

  // Reference model: plain arrays plus the number of sweep cycles still to run.
  logic [XLEN-1:0] m_mem [NUM_REGS];
  bit              m_busy [NUM_REGS];
  int              m_left;
  exp_t            q[$];
  int              tests = 0;
  int              fails = 0;

  function automatic bit valid(input int a);
    return (a >= 0) && (a < NUM_REGS) && (a != 0);
  endfunction

  function automatic bit fwd(input int a, input bit byp);
    return byp && reset_i && reg_write_i && (m_left == 0) && valid(a) &&
           (int'(wr_register_i) == a);
  endfunction

  function automatic logic [XLEN-1:0] rd_d(input int a, input bit byp);
    if (!valid(a)) return '0;
    if (fwd(a, byp)) return wr_data_i;
    return m_mem[a];
  endfunction

  function automatic logic rd_b(input int a, input bit byp);
    if (!valid(a)) return 1'b0;
    if (fwd(a, byp)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_left = 0;
  endtask

  task automatic model_edge(input bit w, input int wa, input logic [XLEN-1:0] wd,
                            input bit is, input int ia, input bit c);
    if (m_left > 0) begin
      m_mem[NUM_REGS - m_left]  = '0;
      m_busy[NUM_REGS - m_left] = 1'b0;
      m_left--;
    end else begin
      if (w && valid(wa)) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (is && valid(ia)) m_busy[ia] = 1'b1;
      if (c) m_left = NUM_REGS;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, queue the expected
  // combinational response, then advance the model across the next edge.
  task automatic step(input bit r, input bit w, input int wa, input logic [XLEN-1:0] wd,
                      input bit is, input int ia, input bit c, input int a0, input int a1);
    exp_t e;
    reset_i          = r;
    reg_write_i      = w;
    wr_register_i    = AW'(wa);
    wr_data_i        = wd;
    issue_i          = is;
    issue_register_i = AW'(ia);
    clear_i          = c;
    rd_register_i    = {AW'(a1), AW'(a0)};
    if (!r) model_reset();
    e.data    = {rd_d(a1, 1'b1), rd_d(a0, 1'b1)};
    e.busy    = {rd_b(a1, 1'b1), rd_b(a0, 1'b1)};
    e.clr     = (m_left > 0);
    e.nb_data = {rd_d(a1, 1'b0), rd_d(a0, 1'b0)};
    e.nb_busy = {rd_b(a1, 1'b0), rd_b(a0, 1'b0)};
    q.push_back(e);
    @(negedge clock_i);
    @(posedge clock_i);
    if (r) model_edge(w, wa, wd, is, ia, c);
    #1;
  endtask

  task automatic rd(input int a0, input int a1);
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, a0, a1);
  endtask

  // Monitor: outputs are combinational, so every falling edge with a queued
  // expectation is a presented response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data",    64'(rd_data_o),     64'(e.data));
        chk("rd_busy",    64'(rd_busy_o),     64'(e.busy));
        chk("clearing",   64'(clearing_o),    64'(e.clr));
        chk("nb_rd_data", 64'(nb_rd_data_o),  64'(e.nb_data));
        chk("nb_rd_busy", 64'(nb_rd_busy_o),  64'(e.nb_busy));
        chk("nb_clearing", 64'(nb_clearing_o), 64'(e.clr));
      end
    end
  end

  initial begin
    model_reset();
    // Reset with random activity on every input, then release.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
           $urandom_range(0, 31), $urandom_range(0, 31));
    rd(1, 2);
    rd(5, 31);
    // Forwarding versus array-only read of x1.
    step(1'b1, 1'b1, 1, 32'h5555_5555, 1'b0, 0, 1'b0, 1, 0);
    rd(1, 1);
    // x0 ignores writes and issues; two ports read different registers.
    step(1'b1, 1'b1, 0, 32'hAAAA_AAAA, 1'b1, 0, 1'b0, 0, 0);
    rd(0, 0);
    step(1'b1, 1'b1, 2, 32'hAAAA_AAAA, 1'b0, 0, 1'b0, 2, 1);
    rd(2, 1);
    // Scoreboard: issue, writeback, then issue and write together.
    step(1'b1, 1'b0, 0, '0, 1'b1, 5, 1'b0, 5, 5);
    rd(5, 1);
    step(1'b1, 1'b1, 5, 32'h0000_1234, 1'b0, 0, 1'b0, 5, 0);
    rd(5, 0);
    step(1'b1, 1'b1, 5, 32'h0000_BEEF, 1'b1, 5, 1'b0, 5, 2);
    rd(5, 2);
    // Full clear sweep with a dropped write and stray clear_i inside it.
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b1, 1, 5);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 3) step(1'b1, 1'b1, 3, 32'h1, 1'b1, 3, 1'b0, 3, 5);
      else step(1'b1, 1'b0, 0, '0, 1'b0, 0, (i == 7), i, $urandom_range(0, 31));
    end
    for (int i = 0; i < NUM_REGS; i += 2) rd(i, i + 1);
    // Reset on the 11th sweep cycle, then a normal write.
    step(1'b1, 1'b1, 9, 32'h9999, 1'b1, 4, 1'b0, 9, 4);
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b1, 9, 4);
    for (int i = 0; i < 10; i++) rd(9, 4);
    step(1'b0, 1'b1, 7, 32'h1111, 1'b0, 0, 1'b0, 9, 4);
    step(1'b1, 1'b1, 7, 32'h0000_CAFE, 1'b0, 0, 1'b0, 7, 9);
    rd(7, 4);
    // Random traffic, occasional clears.
    for (int i = 0; i < 400; i++)
      step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
           1'($urandom_range(0, 2) == 0), $urandom_range(0, 31),
           1'($urandom_range(0, 59) == 0), $urandom_range(0, 31), $urandom_range(0, 31));
    for (int i = 0; i < NUM_REGS + 2; i++) rd(i % NUM_REGS, (i + 7) % NUM_REGS);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
